// File: rtl/bit_serializer.sv
// -----------------------------------------------------------------------------
// bit_serializer
//
// Parallel-to-serial feeder for the serial sequence detector. Accepts WIDTH-bit
// words over a valid/ready handshake and shifts them out one bit per clk on
// sout. A one-word holding buffer lets back-to-back words stream with no idle
// cycle between them. While idle, sout is held at 0 because the downstream
// detector samples every cycle.
//
// Parameters
//   WIDTH      word width in bits (>= 2)
//   MSB_FIRST  1: bit WIDTH-1 leaves first; 0: bit 0 leaves first
//
// Ports
//   clk         clock, all state changes on the rising edge
//   clr         asynchronous active-high reset
//   din         parallel word to serialize
//   din_valid   din is offered this cycle
//   din_ready   a word can be accepted this cycle (registered state only)
//   sout        serial data bit to the detector
//   sout_valid  sout carries a real data bit
//   word_start  sout carries the first bit of a word
//   word_done   sout carries the last bit of a word
//   busy        a word is being shifted or is waiting in the holding buffer
// -----------------------------------------------------------------------------
module bit_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             word_start,
  output logic             word_done,
  output logic             busy
);

  localparam int unsigned     CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]       state;
  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] sh_shifted;
  logic [WIDTH-1:0] hold;
  logic [CW-1:0]    cnt;
  logic             hold_full;
  logic             accept;
  logic             shifting;
  logic             last_bit;
  logic             out_bit;

  // Shift direction and output tap depend only on MSB_FIRST.
  always_comb begin
    sh_shifted = '0;
    out_bit    = 1'b0;
    if (MSB_FIRST) begin
      sh_shifted = {sh[WIDTH-2:0], 1'b0};
      out_bit    = sh[WIDTH-1];
    end else begin
      sh_shifted = {1'b0, sh[WIDTH-1:1]};
      out_bit    = sh[0];
    end
  end

  assign shifting = (state == SHIFT);
  assign last_bit = shifting && (cnt == LAST);

  // Ready depends only on registered state so the source never sees a
  // combinational path from its own valid back to ready.
  assign din_ready = !hold_full;
  assign accept    = din_valid && din_ready;

  assign sout_valid = shifting;
  assign sout       = shifting ? out_bit : 1'b0;
  assign word_start = shifting && (cnt == '0);
  assign word_done  = last_bit;
  assign busy       = shifting || hold_full;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state     <= IDLE;
      sh        <= '0;
      cnt       <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            sh    <= din;
            cnt   <= '0;
            state <= SHIFT;
          end
        end

        SHIFT: begin
          if (cnt == LAST) begin
            // End of word: a held word has priority over a new offer; a new
            // offer on this edge loads straight into the shifter so the
            // stream continues without a bubble.
            cnt <= '0;
            if (hold_full) begin
              sh        <= hold;
              hold_full <= 1'b0;
            end else if (accept) begin
              sh <= din;
            end else begin
              state <= IDLE;
            end
          end else begin
            sh  <= sh_shifted;
            cnt <= cnt + CW'(1);
            if (accept) begin
              hold      <= din;
              hold_full <= 1'b1;
            end
          end
        end

        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/bit_serializer.md
Name: bit_serializer

Overview:
Parallel-to-serial feeder that sits directly upstream of the serial sequence detector. It accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clk on sout, which connects to the detector's serial input. A one-word holding buffer allows back-to-back words to stream without bubbles. Idle cycles present 0 on sout, since the detector samples every cycle.

Parameters:
WIDTH, 8, word width in bits; legal range is WIDTH >= 2.
MSB_FIRST, 1, 1 = shift out bit WIDTH-1 first; 0 = shift out bit 0 first.

Ports:
clk  input  1  clock; all state updates on its rising edge.
clr  input  1  reset; asynchronous, active-high.
din  input  WIDTH  parallel word to serialize.
din_valid  input  1  din is offered this cycle.
din_ready  output  1  block can accept a word this cycle.
sout  output  1  serial bit to the downstream detector.
sout_valid  output  1  sout carries a real data bit.
word_start  output  1  sout carries bit 0 of the word's output order.
word_done  output  1  sout carries the last bit of the word.
busy  output  1  a word is being shifted or is held.

Behaviour:
- State: FSM {IDLE, SHIFT}, shift register sh[WIDTH], bit counter cnt (clog2(WIDTH) bits), holding register hold[WIDTH], flag hold_full.
- Reset (clr=1, any time, async): state=IDLE, sh=0, cnt=0, hold=0, hold_full=0.
- Outputs during and after reset: sout=0, sout_valid=0, din_ready=1, word_start=0, word_done=0, busy=0.
- Reset mid-word discards both the in-flight word and the held word. No word_done is issued for discarded words.
- Accept: a word transfers on a rising edge with din_valid=1 and din_ready=1.
- din_ready = !hold_full. It is a function of registered state only, never of din_valid.
- IDLE:
  - sout_valid=0, sout=0.
  - On accept: sh<=din, cnt<=0, go to SHIFT.
  - Latency is one edge: the first bit appears on sout in the cycle right after the accept edge.
- SHIFT:
  - sout_valid=1.
  - sout = sh[WIDTH-1] when MSB_FIRST=1, else sh[0].
  - Each edge shifts sh by one toward the output end and increments cnt.
  - word_start=1 when cnt==0.
  - word_done=1 when cnt==WIDTH-1.
  - On accept while cnt<WIDTH-1: hold<=din, hold_full<=1.
- End-of-word edge (SHIFT with cnt==WIDTH-1), in priority order:
  - If hold_full: sh<=hold, hold_full<=0, cnt<=0, stay in SHIFT.
  - Else if accept on this same edge: sh<=din, cnt<=0, stay in SHIFT. No bubble.
  - Else: go to IDLE, cnt<=0.
- Accept while hold_full cannot happen, because din_ready=0.
- A continuous stream produces contiguous sout_valid=1. word_done for word N and word_start for word N+1 fall on adjacent cycles.
- busy = sout_valid | hold_full.
- Do not alter din_valid/din semantics: an unaccepted word is simply not sampled. No requirement is placed on the source holding din stable.

Test Plan:
- Reset: assert clr mid-cycle, asynchronously -> immediately sout=0, sout_valid=0, din_ready=1, busy=0, word_start=0, word_done=0.
- Single word, WIDTH=8, MSB_FIRST=1, din=8'hA5 accepted at edge 0:
  - sout = 1,0,1,0,0,1,0,1 in cycles 1..8.
  - word_start in cycle 1 only; word_done in cycle 8 only.
  - sout_valid=0 and sout=0 from cycle 9.
- Back-to-back, din_valid held with 8'hAA at edge 0 then 8'h55 at edge 1:
  - 16 contiguous valid bits: 10101010 01010101.
  - din_ready=0 from after edge 1 through edge 8, 1 again after edge 8.
  - With the detector attached, its match pulses align to the 1010 occurrences in this stream.
- Three words offered continuously (8'h11, 8'h22, 8'h33):
  - The third word waits at din_ready=0 until the first word's last-bit edge, then is accepted.
  - All 24 bits are emitted in order with no gap.
- clr during the 4th bit of 8'hF0:
  - Output drops to reset values at once; the held word is discarded.
  - After release, 8'h0F produces 0,0,0,0,1,1,1,1 cleanly, with word_start on its first bit.
- MSB_FIRST=0, din=8'h0A -> sout = 0,1,0,1,0,0,0,0 over 8 cycles; word_start and word_done framing as above.
